instr_fetch_decode: RTL and testbench

//  Front end of the core, directly upstream of bus_control. Owns the program counter,

---
 rtl/instr_fetch_decode_pkg.sv | 48 ++++
 rtl/instr_fetch_decode_isa_decoder.sv | 23 ++
 rtl/instr_fetch_decode.sv | 112 +++++++++++
 tb/tb_instr_fetch_decode.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_decode_pkg.sv
// Shared ISA encoding, fetch FSM states and small decode helpers.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package instr_fetch_decode_pkg;

  localparam int ISA_INSTRUCTION_COUNT = 11;

  // instruction_en bit positions
  localparam int ISA_ADD   = 0;
  localparam int ISA_SH    = 1;
  localparam int ISA_AND   = 2;
  localparam int ISA_OR    = 3;
  localparam int ISA_XOR   = 4;
  localparam int ISA_CPY   = 5;
  localparam int ISA_CPYPC = 6;
  localparam int ISA_ADDI  = 7;
  localparam int ISA_SHI   = 8;
  localparam int ISA_NOT   = 9;
  localparam int ISA_LB    = 10;

  // 5-bit opcode values carried in ir[7:3]
  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SH    = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_CPY   = 5'd5;
  localparam logic [4:0] OP_CPYPC = 5'd6;
  localparam logic [4:0] OP_ADDI  = 5'd7;
  localparam logic [4:0] OP_SHI   = 5'd8;
  localparam logic [4:0] OP_NOT   = 5'd9;
  localparam logic [4:0] OP_LB    = 5'd10;
  localparam logic [4:0] OP_HALT  = 5'h1F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EXEC,
    ST_HALT
  } fd_state_t;

  // Sign-extend the 3-bit operand field to a full byte immediate.
  function automatic logic [7:0] sext3(input logic [2:0] v);
    return {{5{v[2]}}, v};
  endfunction

endpackage

// File: rtl/instr_fetch_decode_isa_decoder.sv
// Opcode decoder: ir[7:3] to one-hot instruction enable, legal and halt flags.
// Latency: purely combinational.
// Backpressure: none.
module isa_decoder
  import instr_fetch_decode_pkg::*;
(
  input  logic [4:0]                       opcode,
  output logic [ISA_INSTRUCTION_COUNT-1:0] onehot,
  output logic                             legal,
  output logic                             is_halt
);

  // Opcodes below the instruction count map directly to their enable bit.
  always_comb begin
    onehot  = '0;
    legal   = (opcode < 5'(ISA_INSTRUCTION_COUNT));
    is_halt = (opcode == OP_HALT);
    if (legal) begin
      onehot = {{(ISA_INSTRUCTION_COUNT-1){1'b0}}, 1'b1} << opcode;
    end
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Core front end: owns PC, fetches one byte per instruction, decodes and holds it for bus_control.
// Latency: FETCH at t -> instruction_en valid from t+RAM_LATENCY+1; next FETCH the cycle after done.
// Backpressure: decode is held in EXEC until instruction_done; run=0 stops at the next boundary.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                RAM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             run,
  output logic                             ram_rd_en,
  output logic [ADDR_W-1:0]                ram_rd_addr,
  input  logic [7:0]                       ram_rd_data,
  output logic [ISA_INSTRUCTION_COUNT-1:0] instruction_en,
  output logic [2:0]                       reg_num,
  output logic [7:0]                       imm,
  input  logic                             instruction_done,
  output logic [ADDR_W-1:0]                pc,
  input  logic                             pc_load_en,
  input  logic [ADDR_W-1:0]                pc_load_data,
  output logic                             illegal_op,
  output logic                             halted
);

  localparam logic [1:0] WAIT_LAST = 2'(RAM_LATENCY - 1);

  fd_state_t                        state, state_nxt;
  logic [1:0]                       wait_cnt;
  logic [2:0]                       ir_operand;  // only the operand field is needed after decode
  logic                             wait_last;
  logic [ISA_INSTRUCTION_COUNT-1:0] dec_onehot;
  logic                             dec_legal;
  logic                             dec_halt;

  // Decode the word as it returns from RAM so it can be registered at the capture edge.
  isa_decoder u_dec (
    .opcode  (ram_rd_data[7:3]),
    .onehot  (dec_onehot),
    .legal   (dec_legal),
    .is_halt (dec_halt)
  );

  assign wait_last   = (state == ST_WAIT) && (wait_cnt == WAIT_LAST);
  assign ram_rd_en   = (state == ST_FETCH);
  assign ram_rd_addr = pc;
  assign halted      = (state == ST_HALT);
  assign reg_num     = ir_operand;
  assign imm         = sext3(ir_operand);

  // State register; reset discards any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: run is only consulted at instruction boundaries.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (run) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (wait_last) begin
          if (dec_legal)     state_nxt = ST_EXEC;
          else if (dec_halt) state_nxt = ST_HALT;
          else               state_nxt = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_EXEC:  if (instruction_done) state_nxt = run ? ST_FETCH : ST_IDLE;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // PC, operand, decode outputs and wait counter; pc_load only honoured together with done in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= RESET_PC;
      ir_operand     <= '0;
      instruction_en <= '0;
      illegal_op     <= 1'b0;
      wait_cnt       <= '0;
    end else begin
      illegal_op <= 1'b0;
      case (state)
        ST_FETCH: wait_cnt <= '0;
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_last) begin
            ir_operand     <= ram_rd_data[2:0];
            instruction_en <= dec_onehot;
            if (!dec_legal && !dec_halt) begin
              illegal_op <= 1'b1;
              pc         <= pc + 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (instruction_done) begin
            instruction_en <= '0;
            pc             <= pc_load_en ? pc_load_data : pc + 1'b1;
          end
        end
        default: instruction_en <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode with a latency-3 RAM model and a bus_control stand-in.
// Latency: checks decode appears exactly RAM_LATENCY+1 cycles after each fetch strobe.
// Backpressure: the bench holds instruction_done off for several cycles per instruction.
module tb_instr_fetch_decode;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        ram_rd_en;
  logic [7:0]  ram_rd_addr;
  logic [7:0]  ram_rd_data;
  logic [10:0] instruction_en;
  logic [2:0]  reg_num;
  logic [7:0]  imm;
  logic        instruction_done;
  logic [7:0]  pc;
  logic        pc_load_en;
  logic [7:0]  pc_load_data;
  logic        illegal_op;
  logic        halted;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_fetch = 0;

  typedef struct {
    logic [10:0] en;
    logic [2:0]  rn;
    logic [7:0]  imm;
    logic [7:0]  pc;
    logic        ill;
    logic        hlt;
  } exp_t;

  exp_t       eq[$];
  logic [7:0] fq[$];

  logic [7:0] mem  [256];
  logic [7:0] pipe [L];

  instr_fetch_decode #(.ADDR_W(8), .RAM_LATENCY(L), .RESET_PC(8'h00)) dut (
    .clk              (clk),
    .rst              (rst),
    .run              (run),
    .ram_rd_en        (ram_rd_en),
    .ram_rd_addr      (ram_rd_addr),
    .ram_rd_data      (ram_rd_data),
    .instruction_en   (instruction_en),
    .reg_num          (reg_num),
    .imm              (imm),
    .instruction_done (instruction_done),
    .pc               (pc),
    .pc_load_en       (pc_load_en),
    .pc_load_data     (pc_load_data),
    .illegal_op       (illegal_op),
    .halted           (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM read port: data for the address presented at cycle t is visible during cycle t+L.
  always @(posedge clk) begin
    pipe[0] <= ram_rd_addr;
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign ram_rd_data = mem[pipe[L-1]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_e(input logic [10:0] en, input logic [2:0] rn, input logic [7:0] im,
                        input logic [7:0] p, input logic ill, input logic hlt);
    exp_t e;
    e.en = en; e.rn = rn; e.imm = im; e.pc = p; e.ill = ill; e.hlt = hlt;
    eq.push_back(e);
  endtask

  // Monitor: pops an expectation at every decode event and every fetch strobe.
  initial begin
    logic [10:0] prev_en;
    logic        prev_h;
    logic [7:0]  cur_pc;
    logic        ev;
    exp_t        e;
    prev_en = '0; prev_h = 1'b0; cur_pc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en = '0;
        prev_h  = 1'b0;
      end else begin
        ev = (instruction_en != 0 && prev_en == 0) || illegal_op || (halted && !prev_h);
        if (ev) begin
          if (eq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_decode: got en=%h ill=%b hlt=%b expected none", instruction_en, illegal_op, halted);
          end else begin
            e = eq.pop_front();
            chk("instruction_en", 32'(instruction_en), 32'(e.en));
            chk("onehot0", 32'($onehot0(instruction_en)), 32'd1);
            chk("reg_num", 32'(reg_num), 32'(e.rn));
            chk("imm", 32'(imm), 32'(e.imm));
            chk("pc_exec", 32'(pc), 32'(e.pc));
            chk("illegal_op", 32'(illegal_op), 32'(e.ill));
            chk("halted", 32'(halted), 32'(e.hlt));
            chk("decode_latency", 32'(cyc - last_fetch), 32'(L + 1));
            cur_pc = e.pc;
          end
        end else if (instruction_en != 0) begin
          chk("en_hold", 32'(instruction_en), 32'(prev_en));
          chk("pc_hold", 32'(pc), 32'(cur_pc));
        end
        if (ram_rd_en) begin
          if (fq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_fetch: got addr %h expected no fetch", ram_rd_addr);
          end else begin
            chk("fetch_addr", 32'(ram_rd_addr), 32'(fq.pop_front()));
          end
          last_fetch = cyc;
        end
        prev_en = instruction_en;
        prev_h  = halted;
      end
    end
  end

  // bus_control stand-in: wait for a decode, hold it, then pulse done (optionally with a PC load).
  task automatic exec_one(input logic ld, input logic [7:0] ld_dat, input logic glitch, input logic drop_run);
    int n;
    n = 0;
    @(negedge clk);
    while (instruction_en == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      vectors++; miscompares++;
      $display("FAIL exec_timeout: got no instruction_en expected one within 60 cycles");
      return;
    end
    @(negedge clk);
    if (glitch) begin
      pc_load_en = 1'b1; pc_load_data = 8'h77;
      @(negedge clk);
      pc_load_en = 1'b0;
    end
    if (drop_run) run = 1'b0;
    @(negedge clk);
    instruction_done = 1'b1; pc_load_en = ld; pc_load_data = ld_dat;
    @(negedge clk);
    instruction_done = 1'b0; pc_load_en = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; run = 1'b0; instruction_done = 1'b0; pc_load_en = 1'b0; pc_load_data = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h03;  // ADD r3
    mem[8'h01] = 8'h3E;  // ADDI -2
    mem[8'h02] = 8'h2D;  // CPY r5
    mem[8'h03] = 8'h31;  // CPYPC r1
    mem[8'h04] = 8'h52;  // LB r2
    mem[8'h20] = 8'h47;  // SHI -1
    mem[8'hFF] = 8'h4D;  // NOT r5

    repeat (2) @(negedge clk);
    chk("rst_ram_rd_en", 32'(ram_rd_en), 32'd0);
    chk("rst_instruction_en", 32'(instruction_en), 32'd0);
    chk("rst_illegal_op", 32'(illegal_op), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_reg_num", 32'(reg_num), 32'd0);
    chk("rst_imm", 32'(imm), 32'd0);

    // Straight-line, branch, wrap and run-stop sequence.
    fq.push_back(8'h00); push_e(11'h001, 3'd3, 8'h03, 8'h00, 1'b0, 1'b0);
    fq.push_back(8'h01); push_e(11'h080, 3'd6, 8'hFE, 8'h01, 1'b0, 1'b0);
    fq.push_back(8'h02); push_e(11'h020, 3'd5, 8'hFD, 8'h02, 1'b0, 1'b0);
    fq.push_back(8'h03); push_e(11'h040, 3'd1, 8'h01, 8'h03, 1'b0, 1'b0);
    fq.push_back(8'h04); push_e(11'h400, 3'd2, 8'h02, 8'h04, 1'b0, 1'b0);
    fq.push_back(8'h20); push_e(11'h100, 3'd7, 8'hFF, 8'h20, 1'b0, 1'b0);
    fq.push_back(8'hFF); push_e(11'h200, 3'd5, 8'hFD, 8'hFF, 1'b0, 1'b0);
    fq.push_back(8'h00); push_e(11'h001, 3'd3, 8'h03, 8'h00, 1'b0, 1'b0);
    fq.push_back(8'h01); push_e(11'h080, 3'd6, 8'hFE, 8'h01, 1'b0, 1'b0);
    rst = 1'b0; run = 1'b1;
    repeat (4) exec_one(1'b0, 8'h00, 1'b0, 1'b0);
    exec_one(1'b1, 8'h20, 1'b1, 1'b0);   // load ignored without done, then taken with done
    exec_one(1'b1, 8'hFF, 1'b0, 1'b0);
    exec_one(1'b0, 8'h00, 1'b0, 1'b0);   // 0xFF + 1 wraps to 0x00
    exec_one(1'b0, 8'h00, 1'b0, 1'b1);   // run dropped mid-instruction
    repeat (3) @(negedge clk);
    instruction_done = 1'b1; pc_load_en = 1'b1; pc_load_data = 8'h55;  // ignored in IDLE
    @(negedge clk);
    instruction_done = 1'b0; pc_load_en = 1'b0;
    repeat (10) @(negedge clk);
    run = 1'b1;
    exec_one(1'b0, 8'h00, 1'b0, 1'b1);   // resumes at saved pc 1
    repeat (5) @(negedge clk);

    // Illegal opcode then HALT.
    rst = 1'b1;
    mem[8'h00] = 8'hF0;
    mem[8'h01] = 8'hF8;
    fq.push_back(8'h00); push_e(11'h000, 3'd0, 8'h00, 8'h01, 1'b1, 1'b0);
    fq.push_back(8'h01); push_e(11'h000, 3'd0, 8'h00, 8'h01, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0; run = 1'b1;
    repeat (L + 12) @(negedge clk);
    repeat (50) @(negedge clk);
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_no_en", 32'(instruction_en), 32'd0);

    // Asynchronous reset in the middle of WAIT.
    rst = 1'b1;
    mem[8'h00] = 8'h03;
    fq.push_back(8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!ram_rd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      vectors++; miscompares++;
      $display("FAIL fetch_timeout: got no ram_rd_en expected one within 20 cycles");
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ram_rd_en", 32'(ram_rd_en), 32'd0);
    chk("arst_instruction_en", 32'(instruction_en), 32'd0);
    chk("arst_pc", 32'(pc), 32'd0);
    chk("arst_illegal_op", 32'(illegal_op), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    chk("arst_reg_num", 32'(reg_num), 32'd0);
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    fq.push_back(8'h00); push_e(11'h001, 3'd3, 8'h03, 8'h00, 1'b0, 1'b0);
    run = 1'b1;
    exec_one(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (5) @(negedge clk);

    chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
    chk("decode_queue_drained", 32'(eq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
